// File: rtl/safecrack_lock_param.sv
// safecrack_lock_param
// Parametrised combination lock placed between the debounced board buttons and
// switches and the LED / unlock outputs. One digit is taken per button press
// (falling edge of the "all idle" condition). Too many wrong digits lead to a
// lockout that is timed by an external 1 Hz tick. While open, the code can be
// changed by entering a new code and then confirming it.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-low reset
//   btn          active-low buttons, idle = all ones; low bit index = digit
//   ms           code-change request switch (level)
//   lock         relock request (level)
//   tick         one-cycle 1 Hz pulse, only used during lockout
//   unlocked     high while the lock is open
//   locked_out   high during lockout
//   prog_active  high while a new code is being entered or confirmed
//   err_leds     thermometer of wrong digits so far
//   ok_leds      thermometer of digits accepted in the current sequence
//   sec_leds     thermometer of elapsed lockout seconds
module safecrack_lock_param #(
    parameter int BTN_W        = 4,
    parameter int N_DIGITS     = 3,
    parameter int MAX_ERRORS   = 3,
    parameter int LOCKOUT_SECS = 10,
    parameter logic [N_DIGITS*$clog2(BTN_W)-1:0] DEFAULT_CODE = {2'd2, 2'd1, 2'd0}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BTN_W-1:0]        btn,
    input  logic                    ms,
    input  logic                    lock,
    input  logic                    tick,
    output logic                    unlocked,
    output logic                    locked_out,
    output logic                    prog_active,
    output logic [MAX_ERRORS-1:0]   err_leds,
    output logic [N_DIGITS-1:0]     ok_leds,
    output logic [LOCKOUT_SECS-1:0] sec_leds
);

    localparam int IW     = $clog2(BTN_W);
    localparam int IDX_W  = $clog2(N_DIGITS + 1);
    localparam int ERR_W  = $clog2(MAX_ERRORS + 1);
    localparam int SEC_W  = $clog2(LOCKOUT_SECS + 1);
    localparam int CODE_W = N_DIGITS * IW;

    typedef enum logic [2:0] {
        ENTER     = 3'd0,
        ERR_WAIT  = 3'd1,
        LOCKOUT   = 3'd2,
        OPEN      = 3'd3,
        PROG_NEW  = 3'd4,
        PROG_CONF = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [ERR_W-1:0]   err_cnt, err_cnt_next;
    logic [SEC_W-1:0]   sec_cnt, sec_cnt_next;
    logic [CODE_W-1:0]  code, code_next;
    logic [CODE_W-1:0]  shadow, shadow_next;
    logic [BTN_W-1:0]   btn_q;

    logic               btn_idle;
    logic               press;
    logic               valid;
    logic               last_digit;
    logic [IW-1:0]      digit;
    logic [ERR_W-1:0]   err_inc;

    // A press is the first cycle some button is low after a cycle with all
    // buttons idle, so holding a button yields exactly one event. The digit
    // value is only meaningful when exactly one button is low.
    always_comb begin
        btn_idle   = (btn == '1);
        press      = (btn_q == '1) && !btn_idle;
        valid      = $onehot(~btn);
        last_digit = (idx == IDX_W'(N_DIGITS - 1));
        digit      = '0;
        for (int i = 0; i < BTN_W; i++) begin
            if (!btn[i]) begin
                digit = IW'(i);
            end
        end
        // err_cnt saturates so the lockout comparison can never be skipped
        if (err_cnt == ERR_W'(MAX_ERRORS)) begin
            err_inc = err_cnt;
        end else begin
            err_inc = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ENTER;
            idx     <= '0;
            err_cnt <= '0;
            sec_cnt <= '0;
            code    <= DEFAULT_CODE;
            shadow  <= '0;
            btn_q   <= '1;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            err_cnt <= err_cnt_next;
            sec_cnt <= sec_cnt_next;
            code    <= code_next;
            shadow  <= shadow_next;
            btn_q   <= btn;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        err_cnt_next = err_cnt;
        sec_cnt_next = sec_cnt;
        code_next    = code;
        shadow_next  = shadow;

        case (state)
            ENTER: begin
                if (press) begin
                    if (valid && (digit == code[idx*IW +: IW])) begin
                        if (last_digit) begin
                            state_next   = OPEN;
                            idx_next     = '0;
                            err_cnt_next = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else begin
                        idx_next     = '0;
                        err_cnt_next = err_inc;
                        if (err_inc == ERR_W'(MAX_ERRORS)) begin
                            state_next = LOCKOUT;
                        end else begin
                            state_next = ERR_WAIT;
                        end
                    end
                end
            end

            // The offending button is still held; wait for a full release.
            ERR_WAIT: begin
                if (btn_idle) begin
                    state_next = ENTER;
                end
            end

            // The full count is held for one cycle so the last LED is seen.
            LOCKOUT: begin
                if (sec_cnt == SEC_W'(LOCKOUT_SECS)) begin
                    state_next   = ENTER;
                    sec_cnt_next = '0;
                    err_cnt_next = '0;
                end else if (tick) begin
                    sec_cnt_next = sec_cnt + 1'b1;
                end
            end

            OPEN: begin
                if (lock) begin
                    state_next = ENTER;
                    idx_next   = '0;
                end else if (ms) begin
                    state_next = PROG_NEW;
                    idx_next   = '0;
                end
            end

            // Dropping ms aborts and wins over a press in the same cycle.
            PROG_NEW: begin
                if (!ms) begin
                    state_next  = OPEN;
                    idx_next    = '0;
                    shadow_next = '0;
                end else if (press && valid) begin
                    shadow_next[idx*IW +: IW] = digit;
                    if (last_digit) begin
                        state_next = PROG_CONF;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            PROG_CONF: begin
                if (!ms) begin
                    state_next  = OPEN;
                    idx_next    = '0;
                    shadow_next = '0;
                end else if (press) begin
                    if (valid && (digit == shadow[idx*IW +: IW])) begin
                        if (last_digit) begin
                            code_next   = shadow;
                            shadow_next = '0;
                            state_next  = ENTER;
                            idx_next    = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else begin
                        state_next  = OPEN;
                        idx_next    = '0;
                        shadow_next = '0;
                    end
                end
            end

            default: begin
                state_next = ENTER;
                idx_next   = '0;
            end
        endcase
    end

    assign unlocked    = (state == OPEN);
    assign locked_out  = (state == LOCKOUT);
    assign prog_active = (state == PROG_NEW) || (state == PROG_CONF);

    for (genvar k = 0; k < MAX_ERRORS; k++) begin : g_err_leds
        assign err_leds[k] = (err_cnt > ERR_W'(k));
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_ok_leds
        assign ok_leds[k] = (idx > IDX_W'(k));
    end

    for (genvar k = 0; k < LOCKOUT_SECS; k++) begin : g_sec_leds
        assign sec_leds[k] = (sec_cnt > SEC_W'(k));
    end

endmodule

// File: doc/safecrack_lock_param.md
Name: safecrack_lock_param

Overview:
- Parametrised successor to the single-code safe FSM: a combination lock with configurable button count, code length, error limit and lockout duration.
- Adds edge-based press detection with one digit per press, and a two-pass (enter + confirm) code-change flow that is legal only while unlocked.
- Lockout is timed by an external 1 Hz tick, not by raw clocks.
- Sits between the debounced board buttons/switches and the LED/unlock outputs.

Parameters:
- BTN_W, 4, number of active-low buttons; IW = $clog2(BTN_W) is the digit index width.
- N_DIGITS, 3, code length in digits.
- MAX_ERRORS, 3, wrong digits allowed before lockout.
- LOCKOUT_SECS, 10, lockout length in tick pulses.
- DEFAULT_CODE, {2'd2,2'd1,2'd0}, N_DIGITS*IW bits; digit i is at [i*IW +: IW]; loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- btn  in  BTN_W  buttons, active-low; idle = all ones.
- ms  in  1  code-change request switch (level).
- lock  in  1  relock request (level).
- tick  in  1  one-cycle 1 Hz pulse.
- unlocked  out  1  high in OPEN.
- locked_out  out  1  high in LOCKOUT.
- prog_active  out  1  high in PROG_NEW or PROG_CONF.
- err_leds  out  MAX_ERRORS  thermometer of err_cnt.
- ok_leds  out  N_DIGITS  thermometer of idx.
- sec_leds  out  LOCKOUT_SECS  thermometer of elapsed lockout seconds.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=ENTER, idx=0, err_cnt=0, sec_cnt=0, code=DEFAULT_CODE, shadow=0, btn_q=all ones.
  - All outputs 0.
  - Reset overrides every state, including LOCKOUT and PROG.
- Press detection:
  - btn_q is btn registered.
  - press = (btn_q == all ones) && (btn != all ones): one event per press; a held button gives no further events.
  - Valid digit: exactly one bit of btn low; its index is the digit value.
  - Multiple bits low is an invalid press.
- Latency: state and outputs update on the clk edge after the press cycle (1-cycle).
- ENTER, on press:
  - Valid digit equal to code[idx]: idx++. If idx was N_DIGITS-1, go to OPEN with idx=0 and err_cnt=0.
  - Mismatch or invalid press: err_cnt++ and idx=0. If the new err_cnt == MAX_ERRORS, go to LOCKOUT; otherwise go to ERR_WAIT.
- ERR_WAIT:
  - Stay until btn == all ones, then go to ENTER.
  - Presses are impossible here (button still held).
- LOCKOUT:
  - btn, ms and lock are ignored.
  - Each tick: sec_cnt++.
  - When sec_cnt reaches LOCKOUT_SECS, go to ENTER with sec_cnt=0, err_cnt=0, sec_leds=0.
  - sec_leds[k] = (sec_cnt > k).
  - tick in any other state is ignored.
- OPEN:
  - unlocked=1 and button presses are ignored.
  - lock=1: go to ENTER, idx=0.
  - else ms=1: go to PROG_NEW, idx=0.
  - lock has priority over ms.
- PROG_NEW:
  - Valid press: shadow[idx] = digit, idx++. After N_DIGITS digits, go to PROG_CONF with idx=0.
  - Invalid press is ignored.
- PROG_CONF:
  - Valid press equal to shadow[idx]: idx++. After the last match, code = shadow, then go to ENTER with idx=0.
  - Mismatch or invalid press: discard shadow, go to OPEN with idx=0.
  - Confirmation errors never touch err_cnt.
- Abort: ms=0 in PROG_NEW or PROG_CONF discards shadow and returns to OPEN with idx=0. Abort has priority over a same-cycle press.
- Counter widths:
  - err_cnt saturates at MAX_ERRORS.
  - idx is sized $clog2(N_DIGITS+1).
  - sec_cnt is sized $clog2(LOCKOUT_SECS+1).
- Illegal or unused state encodings go to ENTER.

Test Plan:
- Reset, then press buttons 0, 1, 2 (btn 1110, release, 1101, release, 1011) -> ok_leds steps 001/011, then unlocked=1 one cycle after the third press; err_leds=000.
- Press btn 0 held for 20 cycles, then release -> only one digit accepted; ok_leds=001.
- Three wrong presses (btn 0111 each, with releases) -> err_leds 001/011/111 and locked_out=1. Apply 10 tick pulses with presses in between -> sec_leds fills to all ones, then state is ENTER, err_leds=000, and the presses were ignored.
- From OPEN with ms=1, enter 3,3,1 and then confirm 3,3,1 -> prog_active falls and the lock is in ENTER. Code 3,3,1 then unlocks; 0,1,2 gives an error.
- From OPEN, enter 3,3,1 and confirm with 3,2 -> returns to OPEN at the second confirm press, code unchanged, err_leds=000. Separately, drop ms mid PROG_NEW -> OPEN.
- Assert rst=0 mid-LOCKOUT after a code change -> outputs zero next edge; DEFAULT_CODE 0,1,2 unlocks again. lock=1 and ms=1 together in OPEN -> goes to ENTER.
